// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO and its write-side arbiter.
package fifo_pkg;

    typedef logic [7:0] valores_t;
    typedef logic       push_t;

    localparam int unsigned ARB_NUM_REQ_DEF   = 4;
    localparam int unsigned ARB_BURST_LEN_DEF = 4;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority encoder: first set req bit searching upward from rr_ptr, wrapping.
module fifo_rr_pick
    import fifo_pkg::*;
#(
    parameter  int unsigned NUM_REQ = ARB_NUM_REQ_DEF,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int j;

    always_comb begin
        valid = |req;
        idx   = rr_ptr;
        j     = 0;
        // Walk from farthest to nearest so the nearest hit is the last assignment.
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % int'(NUM_REQ);
            if (req[IDX_W'(j)]) begin
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO push port among NUM_REQ producers.
// Defining FIFO_ARB_STATS_EN adds the saturating stall_cnt output.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = ARB_NUM_REQ_DEF,
    parameter  int unsigned BURST_LEN = ARB_BURST_LEN_DEF,
    parameter  int unsigned CNT_W     = 16,
    localparam int unsigned IDX_W     = $clog2(NUM_REQ),
    localparam int unsigned BCNT_W    = $clog2(BURST_LEN + 1),
    localparam int unsigned DATA_W    = $bits(valores_t)
) (
    input  logic                      wrclk,
    input  logic                      wr_rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      full,
    output push_t                     push,
    output valores_t                  data_in,
    output logic [IDX_W-1:0]          owner,
    output logic                      busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]          stall_cnt
`endif
);

    if (NUM_REQ < 2 || BURST_LEN < 1 || CNT_W < 1) begin : g_param_check
        $error("fifo_wr_arbiter: invalid parameters");
    end

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [BCNT_W-1:0] beat_cnt;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  next_ptr;
    valores_t          data_arr [NUM_REQ];

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_data
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
    assign data_in  = data_arr[owner];

    // Reset masks the strobes combinationally so nothing leaks out during wr_rst.
    always_comb begin
        gnt  = '0;
        push = 1'b0;
        if (!wr_rst && state == ARB_BURST) begin
            gnt[owner] = !full;
            push       = req[owner] & !full;
        end
    end

    always_ff @(posedge wrclk) begin
        if (wr_rst) begin
            state    <= ARB_IDLE;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ARB_BURST;
                        busy     <= 1'b1;
                    end
                end
                ARB_BURST: begin
                    if (!req[owner]) begin
                        state  <= ARB_IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end else if (!full) begin
                        if (beat_cnt == BCNT_W'(BURST_LEN - 1)) begin
                            state  <= ARB_IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= next_ptr;
                        end else begin
                            beat_cnt <= beat_cnt + BCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge wrclk) begin
        if (wr_rst) begin
            stall_cnt <= '0;
        end else if (state == ARB_BURST && req[owner] && full && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a cycle-level reference model.
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    localparam int N  = 4;
    localparam int BL = 4;
    localparam int DW = $bits(valores_t);

    logic            wrclk    = 1'b0;
    logic            wr_rst   = 1'b1;
    logic [N-1:0]    req      = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            full     = 1'b0;
    logic [N-1:0]    gnt;
    push_t           push;
    valores_t        data_in;
    logic [1:0]      owner;
    logic            busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]     stall_cnt;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .BURST_LEN (BL),
        .CNT_W     (16)
    ) dut (
        .wrclk     (wrclk),
        .wr_rst    (wr_rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .full      (full),
        .push      (push),
        .data_in   (data_in),
        .owner     (owner),
        .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 wrclk = ~wrclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: which producer holds a burst, beats delivered so far, next start point.
    bit   m_busy;
    int   m_owner;
    int   m_beats;
    int   m_ptr;
    int   m_stall;
    logic [5:0] seq [N];

    logic [N-1:0] last_gnt;
    logic         last_push;
    logic         last_busy;
    logic [1:0]   last_owner;
    int           push_count;
    logic [15:0]  push_hist;
    logic [N-1:0] rnd_req;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic [N-1:0] r, input logic f);
        logic [N-1:0] exp_gnt;
        logic         exp_push;
        valores_t     exp_data;
        bit           found;
        int           j;
        wr_rst = rst;
        req    = r;
        full   = f;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {2'(i), seq[i]};
        @(negedge wrclk);
        exp_gnt  = '0;
        exp_push = 1'b0;
        if (!rst && m_busy && !f) begin
            exp_gnt[m_owner] = 1'b1;
            exp_push         = r[m_owner];
        end
        check_eq("gnt", 32'(gnt), 32'(exp_gnt));
        check_eq("push", 32'(push), 32'(exp_push));
        check_eq("owner", 32'(owner), 32'(m_owner));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (exp_push) begin
            exp_data = {2'(m_owner), seq[m_owner]};
            check_eq("data_in", 32'(data_in), 32'(exp_data));
        end
`ifdef FIFO_ARB_STATS_EN
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        last_gnt   = gnt;
        last_push  = push;
        last_busy  = busy;
        last_owner = owner;
        push_hist  = {push_hist[14:0], push};
        if (push) push_count++;
        @(posedge wrclk);
        if (exp_push) seq[m_owner] = seq[m_owner] + 6'd1;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_stall = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && r[j]) begin
                    found   = 1;
                    m_owner = j;
                end
            end
            if (found) begin
                m_busy  = 1;
                m_beats = 0;
            end
        end else if (!r[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
        end else if (f) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            m_beats++;
            if (m_beats == BL) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        #1;
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, '0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = '0;
        m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_stall = 0;
        push_hist = '0;
        push_count = 0;
        rnd_req = '0;
        @(posedge wrclk);
        #1;

        // Reset with all requests asserted, then all-request round robin.
        cycle(1'b1, 4'hF, 1'b0);
        cycle(1'b1, 4'hF, 1'b0);
        check_eq("rst_gnt", 32'(last_gnt), 32'd0);
        check_eq("rst_push", 32'(last_push), 32'd0);
        cycle(1'b0, 4'hF, 1'b0);
        check_eq("first_idle_gnt", 32'(last_gnt), 32'd0);
        cycle(1'b0, 4'hF, 1'b0);
        check_eq("first_gnt", 32'(last_gnt), 32'b0001);
        for (int i = 0; i < 25; i++) cycle(1'b0, 4'hF, 1'b0);

        // Single producer: 4 on, 1 off repeating.
        reset_cycles(1);
        push_hist = '0;
        for (int i = 0; i < 13; i++) cycle(1'b0, 4'b0100, 1'b0);
        check_eq("single_pattern", 32'(push_hist[12:0]), 32'(13'b0111101111011));

        // Full stall after two beats of producer 1.
        reset_cycles(1);
        push_count = 0;
        cycle(1'b0, 4'b0010, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'b0010, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0010, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'b0010, 1'b0);
        check_eq("stall_beats", 32'(push_count), 32'd4);
`ifdef FIFO_ARB_STATS_EN
        check_eq("stall_total", 32'(stall_cnt), 32'd3);
`endif
        cycle(1'b0, 4'b0000, 1'b0);

        // Voluntary release by producer 1 hands over to producer 3.
        reset_cycles(1);
        cycle(1'b0, 4'b1010, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'b1010, 1'b0);
        cycle(1'b0, 4'b1000, 1'b0);
        cycle(1'b0, 4'b1000, 1'b0);
        check_eq("release_idle", 32'(last_busy), 32'd0);
        cycle(1'b0, 4'b1000, 1'b0);
        check_eq("release_owner", 32'(last_owner), 32'd3);

        // Reset pulse in the middle of a burst.
        reset_cycles(1);
        cycle(1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'b0100, 1'b0);
        cycle(1'b1, 4'b0100, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0);
        check_eq("midrst_busy", 32'(last_busy), 32'd0);
        check_eq("midrst_owner", 32'(last_owner), 32'd0);
        check_eq("midrst_push", 32'(last_push), 32'd0);

        // Randomized traffic with occasional full and reset.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) rnd_req[i] = ~rnd_req[i];
            end
            cycle(($urandom_range(0, 149) == 0), rnd_req, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
